ctrl_decode_stage: RTL and testbench
====================================

Name: ctrl_decode_stage

Overview:
Registered RV32IM control decode stage. It sits between the IF/ID register and EX, and supersedes the single-opcode combinational main decoder. It decodes the full RV32IM base and M opcode set, including LUI, AUIPC, JALR, loads, stores, branches and MUL/DIV, into a control word with a 4-bit ALU control field. The control word is captured in the ID/EX control register with stall and flush handling. A counter sequences multi-cycle MUL/DIV ops, stalling the front end until the op completes.

Parameters:
MUL_LAT, 1, cycles a MUL/MULH* occupies EX (must be >=1)
DIV_LAT, 8, cycles a DIV/REM* occupies EX (must be >=1)
CNT_W, 4, width of the busy counter; must hold max(MUL_LAT,DIV_LAT)-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_i  in  32  instruction from IF/ID
instr_valid_i  in  1  instr_i is valid this cycle
stall_i  in  1  downstream hazard stall: hold the control register
flush_i  in  1  branch/jump redirect: kill the registered op
reg_write_o  out  1  write rd
mem_read_o  out  1  load
mem_write_o  out  1  store
mem_to_reg_o  out  1  writeback from memory
branch_o  out  1  conditional branch
jump_o  out  1  JAL or JALR
jalr_o  out  1  JALR (target = rs1+imm)
alu_src_o  out  1  ALU operand B = immediate
alu_ctrl_o  out  4  ALU operation code (ctrl_pkg)
imm_sel_o  out  3  immediate format I/S/B/U/J (ctrl_pkg)
md_op_o  out  1  op routed to the MUL/DIV unit
ctrl_valid_o  out  1  control word is valid
md_busy_o  out  1  multi-cycle MUL/DIV in progress
stall_fetch_o  out  1  hold PC and IF/ID
illegal_o  out  1  illegal instruction (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, FSM in IDLE, counter 0. The control word equals a NOP.
- Decode is combinational. The result is captured on the clk edge when advance=1.
- advance = !stall_i && !md_busy_o.
- Latency is 1 cycle from instruction to control outputs.
- On capture, ctrl_valid_o = instr_valid_i. If instr_valid_i=0, every control bit is 0 (bubble).
- Opcode map:
  - R (0110011): reg_write; alu_ctrl from funct3/funct7[5]. funct7=0000001 sets md_op.
  - I-ALU (0010011): reg_write, alu_src; alu_ctrl from funct3, with funct7[5] used only for SRAI.
  - LOAD: reg_write, mem_read, mem_to_reg, alu_src, ADD.
  - STORE: mem_write, alu_src, ADD.
  - BRANCH: branch, SUB.
  - JAL: reg_write, jump.
  - JALR: reg_write, jump, jalr, alu_src, ADD.
  - LUI: reg_write, alu_src, PASS_B.
  - AUIPC: reg_write, alu_src, ADD (the PC operand is selected in EX).
  - Any other opcode decodes to a NOP.
- FSM:
  - IDLE -> MD_BUSY when an md_op is captured and its latency LAT>1. LAT is MUL_LAT when funct3[2]=0, DIV_LAT when funct3[2]=1. The counter loads LAT-1.
  - MD_BUSY: the counter decrements each cycle. Return to IDLE when it reaches 1, so the op is held exactly LAT cycles in total.
  - If LAT=1, stay in IDLE.
- md_busy_o=1 exactly while in MD_BUSY. The control register holds its value and ctrl_valid_o stays 1.
- stall_fetch_o = stall_i | md_busy_o (combinational).
- flush_i has priority over stall_i and busy. On the next edge the control word is cleared, ctrl_valid_o=0, FSM -> IDLE, counter -> 0. An md op in flight is aborted.
- flush_i and a new capture in the same cycle: flush wins and nothing is captured.
- stall_i while in MD_BUSY: the counter still decrements; the register stays held until stall_i drops.
- Reset mid-busy: returns to IDLE immediately.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode, or an R-type with funct7 not in {0000000, 0100000, 0000001}, captures as NOP with illegal_o=1 and ctrl_valid_o=1 for that registered slot.
  - illegal_o is cleared on the next capture or on flush.
- Undefined: the same cases capture as a silent NOP and illegal_o is tied to 0.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams
  - ALU control encodings: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B
  - imm_sel encodings: I, S, B, U, J
  - FSM state encodings
- Sub-module ctrl_main_dec is the pure combinational decoder (instr -> control word). ctrl_decode_stage wraps it with the register, FSM and counter.

Test Plan:
- add x1,x2,x3 (0x003100B3), valid -> next cycle ctrl_valid=1, reg_write=1, alu_ctrl=ADD, md_op=0, md_busy=0.
- mul (0x023100B3), MUL_LAT=3 -> md_op=1, md_busy=1 for 2 cycles, stall_fetch=1 for those cycles, control word stable for 3 cycles.
- div (0x023140B3), DIV_LAT=8 -> busy 7 cycles. Assert flush_i on busy cycle 3 -> next edge ctrl_valid=0, md_busy=0, FSM IDLE.
- lw (0x0000A083) with stall_i=1 for 2 cycles -> previously registered word held during the stall; lw captured on the first edge with stall_i=0; mem_read=1, mem_to_reg=1.
- Async reset asserted mid-DIV busy -> all outputs 0 immediately, without waiting for a clk edge.
- 0xFFFFFFFF -> NOP captured; with CTRL_ILLEGAL_TRAP_EN illegal_o=1 for one cycle, without it illegal_o=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the RV32IM control decode stage.
// Opcodes, ALU control codes, immediate formats, FSM states and the
// control word layout. The all-zero control word is a NOP.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    // IMM_NONE keeps the NOP word all-zero; R-type uses no immediate.
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic [2:0] imm_sel;
        logic       md_op;
        logic       illegal;
    } ctrl_word_t;

    // alt selects SUB (funct3=000) or SRA (funct3=101); ignored elsewhere.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3,
                                                    input logic       alt);
        logic [3:0] code;
        case (funct3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ctrl_main_dec.sv
// ctrl_main_dec: combinational RV32IM main decoder, instruction -> control word.
// Unknown opcodes and R-type with an unsupported funct7 decode to a NOP.
// With CTRL_ILLEGAL_TRAP_EN defined, those cases also raise the illegal bit.
module ctrl_main_dec
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_word_t  ctrl
);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register and immediate fields are consumed downstream, not here.
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // Opcode map; every path starts from the NOP word.
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT || funct7 == F7_MULDIV) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_ctrl  = alu_from_funct3(funct3, funct7[5]);
                    ctrl.md_op     = (funct7 == F7_MULDIV);
                end else begin
                    ctrl.illegal = TRAP_EN;
                end
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
                ctrl.imm_sel   = IMM_I;
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_ctrl   = ALU_ADD;
                ctrl.imm_sel    = IMM_I;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.imm_sel   = IMM_S;
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
                ctrl.imm_sel  = IMM_B;
            end
            OP_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.imm_sel   = IMM_J;
            end
            OP_JALR: begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.jalr      = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.imm_sel   = IMM_I;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_PASS_B;
                ctrl.imm_sel   = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.imm_sel   = IMM_U;
            end
            default: begin
                ctrl.illegal = TRAP_EN;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered RV32IM control decode (ID/EX control register).
// Wraps ctrl_main_dec with the capture register, the MUL/DIV busy FSM and its
// down-counter. Optional illegal-instruction flag: CTRL_ILLEGAL_TRAP_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | register captures a new decoded word whenever advance=1
// ST_MD_BUSY | multi-cycle MUL/DIV in EX; word held, counter runs down to 1
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        mem_to_reg_o,
    output logic        branch_o,
    output logic        jump_o,
    output logic        jalr_o,
    output logic        alu_src_o,
    output logic [3:0]  alu_ctrl_o,
    output logic [2:0]  imm_sel_o,
    output logic        md_op_o,
    output logic        ctrl_valid_o,
    output logic        md_busy_o,
    output logic        stall_fetch_o,
    output logic        illegal_o
);

    localparam logic [CNT_W-1:0] MUL_CNT   = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT   = CNT_W'(DIV_LAT - 1);
    localparam logic             MUL_MULTI = (MUL_LAT > 1);
    localparam logic             DIV_MULTI = (DIV_LAT > 1);

    ctrl_word_t       dec;
    ctrl_word_t       ctrl_q;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             valid_q;
    logic             advance;
    logic [CNT_W-1:0] lat_load;
    logic             lat_multi;

    ctrl_main_dec u_main_dec (
        .instr (instr_i),
        .ctrl  (dec)
    );

    assign md_busy_o     = (state == ST_MD_BUSY);
    assign advance       = !stall_i && !md_busy_o;
    assign stall_fetch_o = stall_i | md_busy_o;

    // funct3[2] separates DIV/REM (long) from MUL/MULH* (short).
    always_comb begin
        lat_load  = instr_i[14] ? DIV_CNT : MUL_CNT;
        lat_multi = instr_i[14] ? DIV_MULTI : MUL_MULTI;
    end

    // Control register, busy FSM and counter; flush outranks stall and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            state   <= ST_IDLE;
            cnt     <= '0;
        end else if (flush_i) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            state   <= ST_IDLE;
            cnt     <= '0;
        end else begin
            case (state)
                ST_MD_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    if (advance) begin
                        ctrl_q  <= instr_valid_i ? dec : '0;
                        valid_q <= instr_valid_i;
                        if (instr_valid_i && dec.md_op && lat_multi) begin
                            state <= ST_MD_BUSY;
                            cnt   <= lat_load;
                        end
                    end
                end
            endcase
        end
    end

    assign reg_write_o  = ctrl_q.reg_write;
    assign mem_read_o   = ctrl_q.mem_read;
    assign mem_write_o  = ctrl_q.mem_write;
    assign mem_to_reg_o = ctrl_q.mem_to_reg;
    assign branch_o     = ctrl_q.branch;
    assign jump_o       = ctrl_q.jump;
    assign jalr_o       = ctrl_q.jalr;
    assign alu_src_o    = ctrl_q.alu_src;
    assign alu_ctrl_o   = ctrl_q.alu_ctrl;
    assign imm_sel_o    = ctrl_q.imm_sel;
    assign md_op_o      = ctrl_q.md_op;
    assign illegal_o    = ctrl_q.illegal;
    assign ctrl_valid_o = valid_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage (MUL_LAT=3, DIV_LAT=8).
// Status vector = {ctrl_valid, md_busy, stall_fetch, illegal, word16} where
// word16 = {reg_write, mem_read, mem_write, mem_to_reg, branch, jump, jalr,
//           alu_src, alu_ctrl[3:0], imm_sel[2:0], md_op}.
module tb_ctrl_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        instr_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic        reg_write, mem_read, mem_write, mem_to_reg, branch, jump, jalr, alu_src;
    logic [3:0]  alu_ctrl;
    logic [2:0]  imm_sel;
    logic        md_op, ctrl_valid, md_busy, stall_fetch, illegal;

    int n_cmp = 0;
    int n_err = 0;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic EXP_ILL = 1'b1;
`else
    localparam logic EXP_ILL = 1'b0;
`endif

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_MUL  = 32'h023100B3;
    localparam logic [31:0] I_DIV  = 32'h023140B3;
    localparam logic [31:0] I_SUB  = 32'h403100B3;
    localparam logic [31:0] I_LW   = 32'h0000A083;

    ctrl_decode_stage #(.MUL_LAT(3), .DIV_LAT(8), .CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_i       (instr),
        .instr_valid_i (instr_valid),
        .stall_i       (stall),
        .flush_i       (flush),
        .reg_write_o   (reg_write),
        .mem_read_o    (mem_read),
        .mem_write_o   (mem_write),
        .mem_to_reg_o  (mem_to_reg),
        .branch_o      (branch),
        .jump_o        (jump),
        .jalr_o        (jalr),
        .alu_src_o     (alu_src),
        .alu_ctrl_o    (alu_ctrl),
        .imm_sel_o     (imm_sel),
        .md_op_o       (md_op),
        .ctrl_valid_o  (ctrl_valid),
        .md_busy_o     (md_busy),
        .stall_fetch_o (stall_fetch),
        .illegal_o     (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] stat();
        return {ctrl_valid, md_busy, stall_fetch, illegal,
                reg_write, mem_read, mem_write, mem_to_reg, branch, jump, jalr,
                alu_src, alu_ctrl, imm_sel, md_op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic v);
        instr       = i;
        instr_valid = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(I_ADD, 1'b1);
        #3;
        n_cmp++;
        if (stat() !== 20'h00000) begin
            n_err++;
            $display("FAIL reset_initial: got %h expected %h", stat(), 20'h00000);
        end
        tick();
        tick();
        n_cmp++;
        if (stat() !== 20'h00000) begin
            n_err++;
            $display("FAIL reset_held: got %h expected %h", stat(), 20'h00000);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [31:0] ins [12];
        logic [15:0] exp [12];
        ins = '{32'h003100B3, 32'h403100B3, 32'h003130B3, 32'hFFF10093,
                32'h40315093, 32'h0000A083, 32'h00312023, 32'h00208063,
                32'h008000EF, 32'h000100E7, 32'h123450B7, 32'h00001097};
        exp = '{16'h8000, 16'h8010, 16'h8040, 16'h8102,
                16'h8172, 16'hD102, 16'h2104, 16'h0816,
                16'h840A, 16'h8702, 16'h81A8, 16'h8108};
        for (int k = 0; k < 12; k++) begin
            drive(ins[k], 1'b1);
            tick();
            n_cmp++;
            if (stat() !== {4'b1000, exp[k]}) begin
                n_err++;
                $display("FAIL decode_%0d instr %h: got %h expected %h",
                         k, ins[k], stat(), {4'b1000, exp[k]});
            end
        end
    endtask

    task automatic test_mul();
        logic [19:0] exp [4];
        exp = '{20'hE8001, 20'hE8001, 20'h88001, 20'h88000};
        drive(I_MUL, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) drive(I_ADD, 1'b1);
            n_cmp++;
            if (stat() !== exp[k]) begin
                n_err++;
                $display("FAIL mul_cycle_%0d: got %h expected %h", k, stat(), exp[k]);
            end
        end
    endtask

    task automatic test_div_full();
        int busy_cycles;
        drive(I_DIV, 1'b1);
        tick();
        n_cmp++;
        if (stat() !== 20'hE8051) begin
            n_err++;
            $display("FAIL div_start: got %h expected %h", stat(), 20'hE8051);
        end
        drive(I_ADD, 1'b1);
        busy_cycles = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!md_busy) break;
            busy_cycles++;
        end
        n_cmp++;
        if (busy_cycles !== 7) begin
            n_err++;
            $display("FAIL div_busy_len: got %0d expected %0d", busy_cycles, 7);
        end
        n_cmp++;
        if (stat() !== 20'h88051) begin
            n_err++;
            $display("FAIL div_last_hold: got %h expected %h", stat(), 20'h88051);
        end
        tick();
        n_cmp++;
        if (stat() !== 20'h88000) begin
            n_err++;
            $display("FAIL div_next_capture: got %h expected %h", stat(), 20'h88000);
        end
    endtask

    task automatic test_div_flush();
        drive(I_DIV, 1'b1);
        tick();
        drive(I_ADD, 1'b1);
        tick();
        tick();
        n_cmp++;
        if (stat() !== 20'hE8051) begin
            n_err++;
            $display("FAIL div_busy_c3: got %h expected %h", stat(), 20'hE8051);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (stat() !== 20'h00000) begin
            n_err++;
            $display("FAIL div_flush: got %h expected %h", stat(), 20'h00000);
        end
        tick();
        n_cmp++;
        if (stat() !== 20'h88000) begin
            n_err++;
            $display("FAIL after_flush_capture: got %h expected %h", stat(), 20'h88000);
        end
    endtask

    task automatic test_flush_vs_capture();
        drive(I_SUB, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (stat() !== 20'h00000) begin
            n_err++;
            $display("FAIL flush_wins: got %h expected %h", stat(), 20'h00000);
        end
        tick();
        n_cmp++;
        if (stat() !== 20'h88010) begin
            n_err++;
            $display("FAIL post_flush_sub: got %h expected %h", stat(), 20'h88010);
        end
    endtask

    task automatic test_stall();
        drive(I_LW, 1'b1);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if (stat() !== 20'hA8010) begin
                n_err++;
                $display("FAIL stall_hold_%0d: got %h expected %h", k, stat(), 20'hA8010);
            end
        end
        stall = 1'b0;
        #1;
        n_cmp++;
        if (stat() !== 20'h88010) begin
            n_err++;
            $display("FAIL stall_release_comb: got %h expected %h", stat(), 20'h88010);
        end
        tick();
        n_cmp++;
        if (stat() !== 20'h8D102) begin
            n_err++;
            $display("FAIL stall_lw_capture: got %h expected %h", stat(), 20'h8D102);
        end
    endtask

    task automatic test_stall_in_busy();
        logic [19:0] exp [4];
        exp = '{20'hE8001, 20'hE8001, 20'hA8001, 20'hA8001};
        drive(I_MUL, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                drive(I_ADD, 1'b1);
                stall = 1'b1;
            end
            n_cmp++;
            if (stat() !== exp[k]) begin
                n_err++;
                $display("FAIL busy_stall_%0d: got %h expected %h", k, stat(), exp[k]);
            end
        end
        stall = 1'b0;
        tick();
        n_cmp++;
        if (stat() !== 20'h88000) begin
            n_err++;
            $display("FAIL busy_stall_release: got %h expected %h", stat(), 20'h88000);
        end
    endtask

    task automatic test_bubble();
        drive(I_ADD, 1'b0);
        tick();
        n_cmp++;
        if (stat() !== 20'h00000) begin
            n_err++;
            $display("FAIL bubble: got %h expected %h", stat(), 20'h00000);
        end
    endtask

    task automatic test_illegal();
        drive(32'hFFFFFFFF, 1'b1);
        tick();
        n_cmp++;
        if (stat() !== {1'b1, 1'b0, 1'b0, EXP_ILL, 16'h0000}) begin
            n_err++;
            $display("FAIL illegal_opcode: got %h expected %h", stat(),
                     {1'b1, 1'b0, 1'b0, EXP_ILL, 16'h0000});
        end
        drive(I_ADD, 1'b1);
        tick();
        n_cmp++;
        if (stat() !== 20'h88000) begin
            n_err++;
            $display("FAIL illegal_cleared: got %h expected %h", stat(), 20'h88000);
        end
        drive(32'h043100B3, 1'b1);
        tick();
        n_cmp++;
        if (stat() !== {1'b1, 1'b0, 1'b0, EXP_ILL, 16'h0000}) begin
            n_err++;
            $display("FAIL illegal_funct7: got %h expected %h", stat(),
                     {1'b1, 1'b0, 1'b0, EXP_ILL, 16'h0000});
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (stat() !== 20'h00000) begin
            n_err++;
            $display("FAIL illegal_flush: got %h expected %h", stat(), 20'h00000);
        end
    endtask

    task automatic test_async_reset();
        drive(I_DIV, 1'b1);
        tick();
        drive(I_ADD, 1'b1);
        tick();
        n_cmp++;
        if (stat() !== 20'hE8051) begin
            n_err++;
            $display("FAIL areset_pre_busy: got %h expected %h", stat(), 20'hE8051);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (stat() !== 20'h00000) begin
            n_err++;
            $display("FAIL areset_immediate: got %h expected %h", stat(), 20'h00000);
        end
        tick();
        rst_n = 1'b1;
        drive(I_ADD, 1'b1);
        tick();
        n_cmp++;
        if (stat() !== 20'h88000) begin
            n_err++;
            $display("FAIL areset_idle_capture: got %h expected %h", stat(), 20'h88000);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mul();
        test_div_full();
        test_div_flush();
        test_flush_vs_capture();
        test_stall();
        test_stall_in_busy();
        test_bubble();
        test_illegal();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
